// File: rtl/ecc_conv_pkg.sv
// Shared types and constants for the ECC serial conversion blocks.
// Holds the converter FSM state type, default operand/digit widths and a
// counter-width helper used to size digit counters.
package ecc_conv_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEF_WIDTH = 256;
   localparam int DEF_DIGIT = 32;

   // Bits needed to count 0..n-1; never returns less than 1 so a counter
   // declared from it always has a legal width.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/digit_neg.sv
// Combinational conditional negate-with-borrow on one DIGIT-bit slice.
// With sign=1 computes r = 0 - d - bin and the outgoing borrow; with sign=0
// passes d through and produces no borrow.
module digit_neg #(
   parameter int DIGIT = 32
) (
   input  logic [DIGIT-1:0] d,
   input  logic             sign,
   input  logic             bin,
   output logic [DIGIT-1:0] r,
   output logic             bout
);

   logic [DIGIT-1:0] w_diff;

   // One subtract-with-borrow; a borrow leaves whenever d or the incoming
   // borrow is non-zero, since 0 - d - bin underflows in exactly that case.
   always_comb begin
      w_diff = {DIGIT{1'b0}} - d - DIGIT'(bin);
      r      = sign ? w_diff : d;
      bout   = sign & ((d != {DIGIT{1'b0}}) | bin);
   end

endmodule

// File: rtl/sign_mag_conv.sv
// Word-serial two's-complement to sign-magnitude converter.
// Processes DIGIT bits per cycle through digit_neg, rotating the data
// register right so the magnitude assembles in place. Valid/ready on both
// sides. Optional overflow flag (most-negative input) under SMC_OVF_EN.
module sign_mag_conv
   import ecc_conv_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DIGIT = DEF_DIGIT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] din,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] mag,
`ifdef SMC_OVF_EN
   output logic             ovf,
`endif
   output logic             sign
);

   localparam int NDIG = WIDTH / DIGIT;
   localparam int CW   = clog2(NDIG);
   localparam logic [CW-1:0]    LAST_CNT = CW'(NDIG - 1);
   localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

   state_t           r_state;
   state_t           w_state_next;
   logic [WIDTH-1:0] r_data;
   logic             r_sign;
   logic             r_borrow;
   logic [CW-1:0]    r_cnt;
   logic [DIGIT-1:0] w_r;
   logic             w_bout;
   logic [WIDTH-1:0] w_data_next;

   digit_neg #(.DIGIT(DIGIT)) u_digit_neg (
      .d    (r_data[DIGIT-1:0]),
      .sign (r_sign),
      .bin  (r_borrow),
      .r    (w_r),
      .bout (w_bout)
   );

   // Processed digit enters at the top; after NDIG steps the word is back in place.
   assign w_data_next = {w_r, r_data[WIDTH-1:DIGIT]};

   // State register; synchronous reset aborts any in-flight operation.
   // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_next;
   end

   // Next-state decode.
   // NOTE: the default assignment first keeps this block free of inferred latches.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (in_valid)           w_state_next = RUN;
         RUN:     if (r_cnt == LAST_CNT)  w_state_next = DONE;
         DONE:    if (out_ready)          w_state_next = IDLE;
         default:                         w_state_next = IDLE;
      endcase
   end

   // Datapath: load on accept, one digit per RUN cycle, hold otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_data   <= '0;
         r_sign   <= 1'b0;
         r_borrow <= 1'b0;
         r_cnt    <= '0;
      end else begin
         case (r_state)
            IDLE: if (in_valid) begin
               r_data   <= din;
               r_sign   <= din[WIDTH-1];
               r_borrow <= 1'b0;
               r_cnt    <= '0;
            end
            RUN: begin
               r_data   <= w_data_next;
               r_borrow <= w_bout;
               r_cnt    <= r_cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

`ifdef SMC_OVF_EN
   logic r_ovf;

   // Flag a negative result whose magnitude is 2^(WIDTH-1); cleared on accept.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ovf <= 1'b0;
      end else if (r_state == IDLE && in_valid) begin
         r_ovf <= 1'b0;
      end else if (r_state == RUN && r_cnt == LAST_CNT) begin
         r_ovf <= r_sign && (w_data_next == MIN_NEG);
      end
   end

   assign ovf = r_ovf;
`endif

   assign in_ready  = (r_state == IDLE) && !rst;
   assign out_valid = (r_state == DONE);
   assign mag       = r_data;
   assign sign      = r_sign;

endmodule
